// File: rtl/imem_uart_loader.sv
// Streams a length-prefixed program image from the UART receiver into instruction memory,
// assembling little-endian words and holding the CPU off while the image is loading.
module imem_uart_loader #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 1024,
    parameter int TIMEOUT = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         len_lo_q, len_lo_d;
    logic [15:0]        remain_q, remain_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [15:0]        len_full;

    assign len_full = {rx_data, len_lo_q};

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        remain_d   = remain_q;
        byte_idx_d = byte_idx_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;

        // Inter-byte watchdog shared by every state that is waiting on the UART.
        if ((state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA)) begin
            if (rx_valid) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                state_d = ERROR;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = LEN_LO;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    len_lo_d = rx_data;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    if (len_full == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, len_full} > 17'(DEPTH)) begin
                        state_d = ERROR;
                    end else begin
                        state_d    = DATA;
                        byte_idx_d = 2'd0;
                        remain_d   = len_full;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    wdata_d[8*byte_idx_q +: 8] = rx_data;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_d     = addr_q + 1'b1;
                remain_d   = remain_q - 1'b1;
                byte_idx_d = 2'd0;
                if (remain_q == 16'd1) begin
                    state_d = DONE;
                end else begin
                    state_d = DATA;
                    // A byte landing during the write cycle is the next word's LSB.
                    if (rx_valid) begin
                        wdata_d[7:0] = rx_data;
                        byte_idx_d   = 2'd1;
                        cnt_d        = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        we_d    = (state_d == WRITE);
        busy_d  = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                  (state_d == DATA)   || (state_d == WRITE);
        done_d  = (state_d == DONE);
        error_d = (state_d == ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_lo_q   <= '0;
            remain_q   <= '0;
            byte_idx_q <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            remain_q   <= remain_d;
            byte_idx_q <= byte_idx_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: expected memory writes are queued as bytes are sent
// and matched against each mem_we pulse; status flags are checked at fixed points.
module tb_imem_uart_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [2:0]        dbg_state;

    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] mon_e;
    logic [ADDR_W-1:0]  exp_addr;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    imem_uart_loader #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (1024),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            check("we_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(mon_e[ADDR_W+31:32]));
                check("wr_data", 64'(mem_wdata), 64'(mon_e[31:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        exp_q.push_back({exp_addr, w});
        exp_addr = exp_addr + 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            repeat ($urandom_range(0, max_gap)) tick();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr = '0;
    endtask

    task automatic wait_not_busy(input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("busy_wait_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        exp_addr = '0;
        repeat (3) tick();

        check("rst_we",    64'(mem_we),    64'd0);
        check("rst_addr",  64'(mem_addr),  64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_hold",  64'(cpu_hold),  64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_done",  64'(done),      64'd0);
        check("rst_error", 64'(error),     64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;
        tick();

        // Two-word image, bytes back-to-back.
        pulse_start();
        check("t1_busy", 64'(busy),     64'd1);
        check("t1_hold", 64'(cpu_hold), 64'd1);
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'h0050_0113, 0);
        send_word(32'h0140_0093, 0);
        check("t1_we2",    64'(mem_we),   64'd1);
        check("t1_addr2",  64'(mem_addr), 64'd1);
        check("t1_hold_w", 64'(cpu_hold), 64'd1);
        tick();
        check("t1_hold_fall", 64'(cpu_hold), 64'd0);
        check("t1_done",      64'(done),     64'd1);
        check("t1_error",     64'(error),    64'd0);
        check("t1_we_low",    64'(mem_we),   64'd0);
        check("t1_addr_next", 64'(mem_addr), 64'd2);
        check("t1_pending",   64'(exp_q.size()), 64'd0);

        // Zero-length image.
        pulse_start();
        check("t2_done_clr", 64'(done), 64'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        check("t2_busy",  64'(busy),  64'd0);
        check("t2_done",  64'(done),  64'd1);
        check("t2_error", 64'(error), 64'd0);
        check("t2_hold",  64'(cpu_hold), 64'd0);

        // Oversize image (1025 words).
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h04);
        check("t3_error", 64'(error),    64'd1);
        check("t3_done",  64'(done),     64'd0);
        check("t3_hold",  64'(cpu_hold), 64'd0);
        check("t3_busy",  64'(busy),     64'd0);
        tick();
        check("t3_we", 64'(mem_we), 64'd0);

        // Inter-byte timeout with a partial word, then a clean reload.
        pulse_start();
        check("t4_err_clr", 64'(error), 64'd0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hDE);
        send_byte(8'hAD);
        repeat (15) tick();
        check("t4_no_err_yet", 64'(error), 64'd0);
        check("t4_busy_yet",   64'(busy),  64'd1);
        tick();
        check("t4_error", 64'(error),    64'd1);
        check("t4_hold",  64'(cpu_hold), 64'd0);
        check("t4_we",    64'(mem_we),   64'd0);
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_word($urandom(), 3);
        send_word($urandom(), 3);
        wait_not_busy(50);
        check("t4_reload_done",  64'(done),  64'd1);
        check("t4_reload_error", 64'(error), 64'd0);
        check("t4_pending", 64'(exp_q.size()), 64'd0);

        // rx_valid coinciding with start must not be taken as a length byte.
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        tick();
        start    = 1'b0;
        rx_valid = 1'b0;
        exp_addr = '0;
        send_byte(8'h03);
        send_byte(8'h00);
        for (int i = 0; i < 3; i++) send_word($urandom(), 0);
        check("t5_we3",   64'(mem_we),   64'd1);
        check("t5_addr3", 64'(mem_addr), 64'd2);
        tick();
        check("t5_done",    64'(done), 64'd1);
        check("t5_pending", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of the second word.
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_word($urandom(), 0);
        send_byte(8'h5A);
        rst = 1'b1;
        tick();
        check("t6_we",    64'(mem_we),    64'd0);
        check("t6_addr",  64'(mem_addr),  64'd0);
        check("t6_wdata", 64'(mem_wdata), 64'd0);
        check("t6_hold",  64'(cpu_hold),  64'd0);
        check("t6_busy",  64'(busy),      64'd0);
        check("t6_done",  64'(done),      64'd0);
        check("t6_error", 64'(error),     64'd0);
        check("t6_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'($urandom()));
        tick();
        check("t6_idle_busy",  64'(busy),      64'd0);
        check("t6_idle_state", 64'(dbg_state), 64'd0);
        check("t6_pending",    64'(exp_q.size()), 64'd0);

        // Length exactly DEPTH is accepted; start while loading is ignored.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        check("t7_busy",  64'(busy),      64'd1);
        check("t7_error", 64'(error),     64'd0);
        check("t7_state", 64'(dbg_state), 64'd3);
        pulse_start();
        send_word($urandom(), 0);
        tick();
        check("t7_pending", 64'(exp_q.size()), 64'd0);
        check("t7_still_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
